pc_fetch_unit: RTL and testbench

- Program-counter and next-address stage directly upstream of the instruction decoder/control unit.
- Holds the fetch address `ia` and presents it to instruction memory.
- Computes the next PC from the control unit's `branch`, `jump` and `PCSel` outputs.
- Synchronises and latches the external interrupt and drives the control unit's `irq` and `PC31` inputs. `PC31` marks supervisor mode; interrupts are masked while it is set.

---
 rtl/pc_fetch_unit_if.sv | 33 +++
 rtl/pc_fetch_unit.sv | 87 ++++++++
 tb/tb_pc_fetch_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Bundles the signals between the fetch unit and its surroundings.
// The instruction memory and the control unit sit on one side and the
// PC/fetch unit on the other.
//   master : PC/fetch unit side (drives ia, imem_req, pc_plus4, irq, PC31)
//   slave  : control unit / instruction memory / interrupt source side
interface pc_fetch_unit_if;
    logic        irq_in;      // external interrupt request, asynchronous level
    logic        stall;       // hazard/memory stall, holds the PC
    logic        imem_ready;  // word at ia returned this cycle
    logic        branch;      // active-low branch-taken from the control unit
    logic [1:0]  jump;        // 01 = j/jal, 10 = jr, others = none
    logic [1:0]  PCSel;       // 11 = illegal-opcode trap
    logic [15:0] br_offset;   // branch displacement in words
    logic [25:0] jtarget;     // instruction[25:0]
    logic [31:0] jr_addr;     // register rs value
    logic [31:0] ia;          // current fetch address
    logic        imem_req;    // fetch request
    logic [31:0] pc_plus4;    // link value
    logic        irq;         // pending interrupt to the control unit
    logic        PC31;        // supervisor flag, equals ia[31]

    modport master (
        input  irq_in, stall, imem_ready, branch, jump, PCSel,
               br_offset, jtarget, jr_addr,
        output ia, imem_req, pc_plus4, irq, PC31
    );

    modport slave (
        output irq_in, stall, imem_ready, branch, jump, PCSel,
               br_offset, jtarget, jr_addr,
        input  ia, imem_req, pc_plus4, irq, PC31
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and next-address stage feeding the instruction decoder.
// Holds the fetch address, selects the next PC from the control unit's
// branch/jump/PCSel outputs, and synchronises and latches the external
// interrupt. Bit 31 of the PC is the supervisor flag; interrupts are held
// pending (not taken) while it is set.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : pc_fetch_unit_if.master (control inputs, fetch outputs)
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADDR_VEC = 32'h8000_0008
) (
    input logic             clk,
    input logic             reset,
    pc_fetch_unit_if.master bus
);

    logic [31:0]        ia_q, ia_d;
    logic               irq_q, irq_d;
    logic               req_q;
    logic               sync1_q, sync2_q, hist_q;

    logic [31:0]        pc_plus4;
    logic signed [31:0] br_disp;
    logic [31:0]        br_target;
    logic [31:0]        next_pc;
    logic               advance;
    logic               take_irq;
    logic               irq_edge;

    // Stage 0: next-address selection
    always_comb begin
        // Increment touches only bits 30:0 so the supervisor flag survives wrap.
        pc_plus4  = {ia_q[31], ia_q[30:0] + 31'd4};
        br_disp   = {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};
        br_target = {ia_q[31], pc_plus4[30:0] + br_disp[30:0]};
        advance   = bus.imem_ready & ~bus.stall;
        take_irq  = irq_q & ~ia_q[31];
        irq_edge  = sync2_q & ~hist_q;

        if (take_irq) begin
            next_pc = XADDR_VEC;
        end else if (bus.PCSel == 2'b11) begin
            next_pc = ILLOP_VEC;
        end else if (bus.jump == 2'b01) begin
            next_pc = {ia_q[31], pc_plus4[30:28], bus.jtarget, 2'b00};
        end else if (bus.jump == 2'b10) begin
            // jr may drop out of supervisor mode but can never enter it.
            next_pc = {bus.jr_addr[31] & ia_q[31], bus.jr_addr[30:2], 2'b00};
        end else if (!bus.branch) begin
            next_pc = br_target;
        end else begin
            next_pc = pc_plus4;
        end

        ia_d  = advance ? next_pc : ia_q;
        // A fresh edge wins over the clear so no request is ever lost.
        irq_d = irq_edge | (irq_q & ~(advance & take_irq));
    end

    // Stage 1: architectural state and interrupt synchroniser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ia_q    <= RESET_VEC;
            irq_q   <= 1'b0;
            req_q   <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            ia_q    <= ia_d;
            irq_q   <= irq_d;
            req_q   <= 1'b1;
            sync1_q <= bus.irq_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign bus.ia       = ia_q;
    assign bus.imem_req = req_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.irq      = irq_q;
    assign bus.PC31     = ia_q[31];

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    // Reference model state: architectural view only.
    logic [31:0] m_ia;
    logic        m_irq;
    logic        m_req;
    logic        smp [3];   // irq_in sampled at the last three clock edges, [0] newest

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ia  = 32'h8000_0000;
        m_irq = 1'b0;
        m_req = 1'b0;
        for (int i = 0; i < 3; i++) smp[i] = 1'b0;
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic pend);
        logic [30:0] inc;
        int          off;
        inc = pc[30:0] + 31'd4;
        off = $signed(bus.br_offset);
        if (pend && !pc[31])       return 32'h8000_0008;
        if (bus.PCSel == 2'b11)    return 32'h8000_0004;
        if (bus.jump == 2'b01)     return {pc[31], inc[30:28], bus.jtarget, 2'b00};
        if (bus.jump == 2'b10)     return {bus.jr_addr[31] & pc[31], bus.jr_addr[30:2], 2'b00};
        if (!bus.branch)           return {pc[31], 31'(inc + 31'(off * 4))};
        return {pc[31], inc};
    endfunction

    // One clock: predict from the spec rules, clock, then compare everything.
    task automatic tick();
        logic        adv;
        logic        edge_seen;
        logic [31:0] n_ia;
        logic        n_irq;
        adv       = bus.imem_ready & ~bus.stall;
        // irq_in seen high two edges ago after being low three edges ago
        edge_seen = smp[1] & ~smp[2];
        n_ia      = adv ? ref_next(m_ia, m_irq) : m_ia;
        n_irq     = edge_seen | (m_irq & ~(adv & ~m_ia[31]));
        smp[2]    = smp[1];
        smp[1]    = smp[0];
        smp[0]    = bus.irq_in;
        @(posedge clk);
        #1;
        m_ia  = n_ia;
        m_irq = n_irq;
        m_req = 1'b1;
        chk("ia",       bus.ia,       m_ia);
        chk("irq",      {31'd0, bus.irq},      {31'd0, m_irq});
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, m_req});
        chk("PC31",     {31'd0, bus.PC31},     {31'd0, m_ia[31]});
        chk("pc_plus4", bus.pc_plus4, {m_ia[31], m_ia[30:0] + 31'd4});
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic br,
                         input logic [1:0] jmp, input logic [1:0] sel);
        bus.imem_ready = rdy;
        bus.stall      = stl;
        bus.branch     = br;
        bus.jump       = jmp;
        bus.PCSel      = sel;
    endtask

    task automatic run_jr(input logic [31:0] addr);
        drive(1'b1, 1'b0, 1'b1, 2'b10, 2'b00);
        bus.jr_addr = addr;
        tick();
    endtask

    task automatic run_j(input logic [25:0] tgt);
        drive(1'b1, 1'b0, 1'b1, 2'b01, 2'b00);
        bus.jtarget = tgt;
        tick();
    endtask

    // Pulse irq_in for one cycle while stalled, leaving irq pending.
    task automatic irq_pulse_stalled();
        drive(1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
        bus.irq_in = 1'b1;
        tick();
        bus.irq_in = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.irq_in    = 1'b0;
        bus.br_offset = 16'h0;
        bus.jtarget   = 26'h0;
        bus.jr_addr   = 32'h0;
        drive(1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
        model_reset();
        #12;
        chk("rst_ia",  bus.ia, 32'h8000_0000);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        reset = 1'b1;

        // Sequential fetch out of reset
        tick();
        chk("seq1", bus.ia, 32'h8000_0004);
        chk("req1", {31'd0, bus.imem_req}, 32'd1);
        tick();
        chk("seq2", bus.ia, 32'h8000_0008);

        // Backward branch, then the same with a stall
        run_jr(32'h0000_0100);
        chk("jr_user", bus.ia, 32'h0000_0100);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        bus.br_offset = 16'hFFFE;
        tick();
        chk("branch_back", bus.ia, 32'h0000_00FC);
        run_j(26'h0000040);
        chk("j_100", bus.ia, 32'h0000_0100);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", bus.ia, 32'h0000_0100);
        end
        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        chk("branch_after_stall", bus.ia, 32'h0000_00FC);
        drive(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        tick();
        chk("not_ready_hold", bus.ia, 32'h0000_00FC);

        // Jumps
        run_j(26'h0000080);
        chk("j_200", bus.ia, 32'h0000_0200);
        run_j(26'h0000040);
        chk("j_from_200", bus.ia, 32'h0000_0100);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 2'b11);
        tick();
        chk("illop", bus.ia, 32'h8000_0004);
        run_j(26'h0000004);
        chk("j_super", bus.ia, 32'h8000_0010);
        run_jr(32'h0000_0403);
        chk("jr_low_bits", bus.ia, 32'h0000_0400);
        run_j(26'h0000004);
        chk("j_10", bus.ia, 32'h0000_0010);
        run_jr(32'h8000_0000);
        chk("jr_no_enter", bus.ia, 32'h0000_0000);

        // Interrupt taken from user mode
        run_j(26'h0000010);
        chk("j_40", bus.ia, 32'h0000_0040);
        irq_pulse_stalled();
        chk("irq_pending", {31'd0, bus.irq}, 32'd1);
        chk("irq_stall_hold", bus.ia, 32'h0000_0040);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
        tick();
        chk("irq_vector", bus.ia, 32'h8000_0008);
        chk("irq_cleared", {31'd0, bus.irq}, 32'd0);

        // Interrupt masked in supervisor mode until jr to user
        bus.irq_in = 1'b1;
        tick();
        bus.irq_in = 1'b0;
        tick();
        tick();
        tick();
        chk("irq_masked_pend", {31'd0, bus.irq}, 32'd1);
        chk("irq_masked_ia", bus.ia, 32'h8000_0018);
        run_jr(32'h0000_0080);
        chk("jr_80", bus.ia, 32'h0000_0080);
        chk("irq_still_pend", {31'd0, bus.irq}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
        tick();
        chk("irq_late_vector", bus.ia, 32'h8000_0008);
        chk("irq_late_clear", {31'd0, bus.irq}, 32'd0);

        // Priority: trap over jump/branch, interrupt over trap
        run_jr(32'h0000_0300);
        drive(1'b1, 1'b0, 1'b0, 2'b01, 2'b11);
        tick();
        chk("prio_illop", bus.ia, 32'h8000_0004);
        run_jr(32'h0000_0300);
        irq_pulse_stalled();
        drive(1'b1, 1'b0, 1'b0, 2'b01, 2'b11);
        tick();
        chk("prio_irq", bus.ia, 32'h8000_0008);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
            bus.br_offset = 16'($urandom);
            bus.jtarget   = 26'($urandom);
            bus.jr_addr   = $urandom;
            if ($urandom_range(0, 5) == 0) bus.irq_in = ~bus.irq_in;
            tick();
        end

        // Asynchronous reset with an interrupt pending
        bus.irq_in = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) tick();
        drive(1'b1, 1'b0, 1'b1, 2'b00, 2'b11);
        tick();
        irq_pulse_stalled();
        chk("pre_reset_irq", {31'd0, bus.irq}, 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst_ia",  bus.ia, 32'h8000_0000);
        chk("async_rst_irq", {31'd0, bus.irq}, 32'd0);
        chk("async_rst_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
        tick();
        chk("post_rst_ia", bus.ia, 32'h8000_0004);
        tick();
        chk("post_rst_irq", {31'd0, bus.irq}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
